// File: rtl/rr_mux16_arbiter_pkg.sv
// Shared constants and helpers for the 16-source round-robin arbiter.
// NREQ and SEL_W must stay consistent (NREQ == 2**SEL_W).
package rr_mux16_arbiter_pkg;

  localparam int NREQ  = 16;
  localparam int SEL_W = 4;

  function automatic logic [NREQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux16_arbiter_mux16x1N.sv
// Plain 16:1 N-bit word selector used as the shared datapath of the arbiter.
module mux16x1N
  import rr_mux16_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     D [NREQ],
  input  logic [SEL_W-1:0] S,
  output logic [N-1:0]     Y
);

  assign Y = D[S];

endmodule

// File: rtl/rr_mux16_arbiter.sv
// Round-robin arbiter over 16 requesters feeding one registered output word
// with a valid/ready handshake toward a single consumer.
module rr_mux16_arbiter
  import rr_mux16_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] data_in,
  output logic [NREQ-1:0]   grant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic [SEL_W-1:0]  out_src
);

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  out_src_q, out_src_d;
  logic [N-1:0]      out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [SEL_W-1:0]  offset;
  logic              found;
  logic [SEL_W-1:0]  winner;
  logic              cap_en;
  logic [N-1:0]      mux_y;
  logic [N-1:0]      d_words [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign d_words[gi] = data_in[gi*N +: N];
  end

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    req_dbl = {req, req};
    req_rot = NREQ'(req_dbl >> ptr_q);
    offset  = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        offset = SEL_W'(k);
      end
    end
    winner = ptr_q + offset;
  end

  assign cap_en = rst_n & (|req) & (~out_valid_q | out_ready);
  assign grant  = cap_en ? onehot16(winner) : '0;

  mux16x1N #(.N(N)) u_mux (
    .D (d_words),
    .S (winner),
    .Y (mux_y)
  );

  always_comb begin
    ptr_d       = ptr_q;
    out_src_d   = out_src_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (cap_en) begin
      out_data_d  = mux_y;
      out_src_d   = winner;
      out_valid_d = 1'b1;
      ptr_d       = winner + SEL_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_src_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_src_q   <= out_src_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux16_arbiter.sv
// Self-checking bench for rr_mux16_arbiter: directed scenarios plus a
// randomized run against a behavioural round-robin model.
module tb_rr_mux16_arbiter;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [15:0]    req = '0;
  logic [16*N-1:0] data_in = '0;
  logic [15:0]    grant;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [N-1:0]   out_data;
  logic [3:0]     out_src;

  rr_mux16_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;

  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic [N-1:0] m_data = '0;
  logic [3:0]  m_src = '0;
  logic [15:0] g_obs, g_exp;

  function automatic int m_winner(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  // One clock: apply inputs at the falling edge, sample grant, advance the model at the rising edge.
  task automatic drive_cycle(input logic rst, input logic [15:0] r, input logic rdy);
    int w;
    bit cap;
    @(negedge clk);
    rst_n = rst;
    req = r;
    out_ready = rdy;
    #1;
    g_obs = grant;
    w = m_winner(r, m_ptr);
    cap = rst && (r != 16'h0) && (!m_valid || rdy);
    g_exp = cap ? (16'h1 << w) : 16'h0;
    @(posedge clk);
    if (!rst) begin
      m_valid = 1'b0;
      m_data = '0;
      m_src = '0;
      m_ptr = 0;
    end else if (cap) begin
      m_data = data_in[w*N +: N];
      m_src = 4'(w);
      m_valid = 1'b1;
      m_ptr = (w + 1) % 16;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive_cycle(1'b0, 16'hFFFF, 1'b1);
      n_vec++; if (g_obs !== 16'h0) begin n_err++; $display("FAIL reset_grant: got %h expected 0000", g_obs); end
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", out_data); end
    n_vec++; if (out_src !== 4'h0) begin n_err++; $display("FAIL reset_src: got %0d expected 0", out_src); end
    drive_cycle(1'b1, 16'hFFFF, 1'b1);
    n_vec++; if (g_obs !== 16'h0001) begin n_err++; $display("FAIL reset_first_winner: got %h expected 0001", g_obs); end
  endtask

  task automatic test_single();
    drive_cycle(1'b0, 16'h0000, 1'b1);
    data_in[5*N +: N] = 8'hA5;
    drive_cycle(1'b1, 16'h0020, 1'b1);
    n_vec++; if (g_obs !== 16'h0020) begin n_err++; $display("FAIL single_grant: got %h expected 0020", g_obs); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    n_vec++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h expected a5", out_data); end
    n_vec++; if (out_src !== 4'd5) begin n_err++; $display("FAIL single_src: got %0d expected 5", out_src); end
    drive_cycle(1'b1, 16'hFFFF, 1'b1);
    n_vec++; if (g_obs !== 16'h0040) begin n_err++; $display("FAIL single_next_ptr: got %h expected 0040", g_obs); end
  endtask

  task automatic test_round_robin();
    logic [15:0] e;
    logic [N-1:0] d;
    drive_cycle(1'b0, 16'hFFFF, 1'b1);
    for (int k = 0; k < 17; k++) begin
      drive_cycle(1'b1, 16'hFFFF, 1'b1);
      e = 16'h1 << (k % 16);
      d = data_in[(k % 16)*N +: N];
      n_vec++; if (g_obs !== e) begin n_err++; $display("FAIL rr_grant[%0d]: got %h expected %h", k, g_obs, e); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b expected 1", k, out_valid); end
      n_vec++; if (out_src !== 4'(k % 16)) begin n_err++; $display("FAIL rr_src[%0d]: got %0d expected %0d", k, out_src, k % 16); end
      n_vec++; if (out_data !== d) begin n_err++; $display("FAIL rr_data[%0d]: got %h expected %h", k, out_data, d); end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] held;
    drive_cycle(1'b0, 16'h0000, 1'b1);
    drive_cycle(1'b1, 16'h0004, 1'b1);
    held = data_in[2*N +: N];
    n_vec++; if (out_src !== 4'd2) begin n_err++; $display("FAIL bp_first_src: got %0d expected 2", out_src); end
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b1, 16'hFFFF, 1'b0);
      n_vec++; if (g_obs !== 16'h0) begin n_err++; $display("FAIL bp_grant[%0d]: got %h expected 0000", c, g_obs); end
      n_vec++; if (out_src !== 4'd2 || out_data !== held || out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold[%0d]: got src %0d data %h valid %b expected src 2 data %h valid 1", c, out_src, out_data, out_valid, held);
      end
    end
    drive_cycle(1'b1, 16'hFFFF, 1'b1);
    n_vec++; if (g_obs !== 16'h0008) begin n_err++; $display("FAIL bp_release_grant: got %h expected 0008", g_obs); end
    n_vec++; if (out_src !== 4'd3) begin n_err++; $display("FAIL bp_release_src: got %0d expected 3", out_src); end
  endtask

  task automatic test_two_sources();
    drive_cycle(1'b0, 16'h0000, 1'b1);
    drive_cycle(1'b1, 16'h0008, 1'b1);
    drive_cycle(1'b1, 16'h1008, 1'b1);
    n_vec++; if (g_obs !== 16'h1000) begin n_err++; $display("FAIL two_first: got %h expected 1000", g_obs); end
    drive_cycle(1'b1, 16'h0008, 1'b1);
    n_vec++; if (g_obs !== 16'h0008) begin n_err++; $display("FAIL two_second: got %h expected 0008", g_obs); end
    drive_cycle(1'b1, 16'hFFFF, 1'b1);
    n_vec++; if (g_obs !== 16'h0010) begin n_err++; $display("FAIL two_ptr_end: got %h expected 0010", g_obs); end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b0, 16'h0000, 1'b1);
    drive_cycle(1'b1, 16'h0100, 1'b1);
    drive_cycle(1'b1, 16'hFFFF, 1'b0);
    n_vec++; if (g_obs !== 16'h0 || out_valid !== 1'b1) begin n_err++; $display("FAIL mid_stall: got grant %h valid %b expected 0000 1", g_obs, out_valid); end
    drive_cycle(1'b0, 16'hFFFF, 1'b0);
    n_vec++; if (out_valid !== 1'b0 || out_src !== 4'd0 || out_data !== 8'h00) begin
      n_err++; $display("FAIL mid_reset: got valid %b src %0d data %h expected 0 0 00", out_valid, out_src, out_data);
    end
    drive_cycle(1'b1, 16'hFFFF, 1'b1);
    n_vec++; if (g_obs !== 16'h0001) begin n_err++; $display("FAIL mid_next_winner: got %h expected 0001", g_obs); end
  endtask

  task automatic test_random();
    logic [15:0] held, r;
    logic rst, rdy;
    int wait_cnt [16];
    for (int i = 0; i < 16; i++) wait_cnt[i] = 0;
    held = '0;
    for (int c = 0; c < 600; c++) begin
      r = held | (16'($urandom) & 16'($urandom));
      for (int i = 0; i < 16; i++) begin
        if (!held[i]) data_in[i*N +: N] = 8'($urandom);
      end
      rst = ($urandom_range(0, 59) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive_cycle(rst, r, rdy);
      n_vec++; if (g_obs !== g_exp) begin n_err++; $display("FAIL rand_grant[%0d]: got %h expected %h", c, g_obs, g_exp); end
      n_vec++; if (out_valid !== m_valid || out_data !== m_data || out_src !== m_src) begin
        n_err++; $display("FAIL rand_out[%0d]: got v%b d%h s%0d expected v%b d%h s%0d", c, out_valid, out_data, out_src, m_valid, m_data, m_src);
      end
      if (!rst) begin
        for (int i = 0; i < 16; i++) wait_cnt[i] = 0;
      end else if (g_obs != 16'h0) begin
        for (int i = 0; i < 16; i++) begin
          if (g_obs[i]) wait_cnt[i] = 0;
          else if (r[i]) wait_cnt[i]++;
        end
        for (int i = 0; i < 16; i++) begin
          if (r[i]) begin
            n_vec++; if (wait_cnt[i] > 15) begin n_err++; $display("FAIL rand_fair[%0d]: src %0d waited %0d captures expected <= 15", c, i, wait_cnt[i]); end
          end
        end
      end
      held = r & ~g_obs;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) data_in[i*N +: N] = 8'($urandom);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_two_sources();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
